// File: rtl/shift_add_mult_if.sv
// Operand/result handshake bundle for the shift-add multiplier.
// The master side issues operands and consumes the product; the slave side
// is the multiplier itself.
interface shift_add_mult_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/shift_add_mult.sv
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH multiplier, one shift-add step
// per clock. The addition itself is done by an external ripple-carry adder
// reached through the add_* ports; its sum and final carry come back in the
// same cycle.
// Optional feature macro: SHIFT_ADD_MULT_ZERO_BYPASS_EN -- when defined, a zero
// operand skips the iteration and goes straight to the result state.
module shift_add_mult #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_add_mult_if.slave  bus,
  output logic             busy,
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_z,
  input  logic             add_cout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;
  logic             last_step;

  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // Sequencer and datapath: load operands, shift-add WIDTH times, hold result.
  // acc_lo starts as the multiplier and is shifted out from the bottom while
  // product bits enter from the top, so its LSB is always the current
  // multiplier bit. The adder carry becomes the new top bit of acc_hi.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= bus.in_a;
            acc_hi <= '0;
            cnt    <= '0;
`ifdef SHIFT_ADD_MULT_ZERO_BYPASS_EN
            if ((bus.in_a == '0) || (bus.in_b == '0)) begin
              acc_lo <= '0;
              state  <= DONE;
            end else begin
              acc_lo <= bus.in_b;
              state  <= RUN;
            end
`else
            acc_lo <= bus.in_b;
            state  <= RUN;
`endif
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= {add_cout, add_z, acc_lo[WIDTH-1:1]};
          cnt              <= cnt + CNT_W'(1);
          if (last_step) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake/status flags and adder operands, all decoded from registers so
  // they are defined (not X) from reset onward.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.out_p     = {acc_hi, acc_lo};
    busy          = (state == RUN);
    add_x         = acc_hi;
    add_y         = acc_lo[0] ? mcand : '0;
    add_cin       = 1'b0;
  end

endmodule
